// File: rtl/dac_tx_sequencer_if.sv
// FIFO-side and DAC-side signals of the DAC transmit sequencer.
// The master modport is the sequencer. The slave modport is the FIFO/serializer side.
interface dac_tx_sequencer_if;
  logic        fifo_empty;
  logic [31:0] fifo_dout;
  logic        fifo_rd_en;
  logic [15:0] dac_data;
  logic        channel_sync;
  logic        frame_sync;

  modport master (
    input  fifo_empty,
    input  fifo_dout,
    output fifo_rd_en,
    output dac_data,
    output channel_sync,
    output frame_sync
  );

  modport slave (
    output fifo_empty,
    output fifo_dout,
    input  fifo_rd_en,
    input  dac_data,
    input  channel_sync,
    input  frame_sync
  );
endinterface

// File: rtl/dac_tx_sequencer.sv
// DAC transmit sequencer. It splits 32-bit IQ words (I in [31:16], Q in [15:0])
// into two half-words on consecutive DAC clocks for a DDR serializer.
// The word source is the FWFT sample FIFO or a constant test word.
// A run of consecutive underruns halts the output until enable is dropped.
module dac_tx_sequencer #(
  parameter int unsigned UNDERRUN_LIMIT = 16,  // legal range 1..255
  parameter int unsigned CNT_W          = 16
) (
  input  logic               clk_dac0,
  input  logic               reset,
  input  logic               enable,
  input  logic               test_mode,
  input  logic [31:0]        test_word,
  input  logic               clr_status,
  dac_tx_sequencer_if.master bus,
  output logic               running,
  output logic               underrun_flag,
  output logic [CNT_W-1:0]   underrun_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2,
    HALT  = 2'd3
  } state_t;

  localparam logic [7:0]       HALT_AT = 8'(UNDERRUN_LIMIT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t      state;
  state_t      state_nxt;
  logic        ph;            // 0: word boundary (I half next), 1: Q half next
  logic [15:0] q_latch;       // Q half held for the ph=1 cycle
  logic [7:0]  consec_cnt;    // consecutive underrun words

  logic        word_slot;
  logic        fifo_pop;
  logic        underrun_evt;
  logic        halt_hit;
  logic [31:0] source;

  // Word-slot decode. Enable and test_mode are only looked at on the word boundary.
  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    word_slot    = (state == RUN) && !ph && enable;
    fifo_pop     = word_slot && !test_mode && !bus.fifo_empty;
    underrun_evt = word_slot && !test_mode && bus.fifo_empty;
    halt_hit     = underrun_evt && (consec_cnt == HALT_AT);
    source       = 32'd0;
    if (test_mode) begin
      source = test_word;
    end else if (fifo_pop) begin
      source = bus.fifo_dout;
    end
  end

  // Pop strobe. It is masked by reset so no word is consumed during reset.
  assign bus.fifo_rd_en = fifo_pop && !reset;

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (enable) state_nxt = PRIME;
      PRIME: begin
        if (!enable) begin
          state_nxt = IDLE;
        end else if (test_mode || !bus.fifo_empty) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (!ph) begin
          if (!enable) begin
            state_nxt = IDLE;
          end else if (halt_hit) begin
            state_nxt = HALT;
          end
        end
      end
      HALT:  if (!enable) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register, phase bit and consecutive-underrun counter.
  // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values.
  always_ff @(posedge clk_dac0) begin
    if (reset) begin
      state      <= IDLE;
      ph         <= 1'b0;
      consec_cnt <= 8'd0;
    end else begin
      state <= state_nxt;
      ph    <= (state == RUN && state_nxt == RUN) ? ~ph : 1'b0;
      if (state == IDLE) begin
        consec_cnt <= 8'd0;
      end else if (underrun_evt) begin
        consec_cnt <= consec_cnt + 8'd1;
      end else if (word_slot) begin
        consec_cnt <= 8'd0;
      end
    end
  end

  // Output half-word path. The I half is sent on the word boundary and the Q half follows. Outside RUN the outputs are zero.
  always_ff @(posedge clk_dac0) begin
    if (reset) begin
      bus.dac_data     <= 16'd0;
      bus.channel_sync <= 1'b0;
      bus.frame_sync   <= 1'b0;
      q_latch          <= 16'd0;
      running          <= 1'b0;
    end else begin
      running <= (state_nxt == RUN);
      if (word_slot) begin
        bus.dac_data     <= source[31:16];
        bus.channel_sync <= 1'b1;
        bus.frame_sync   <= ~bus.frame_sync;
        q_latch          <= source[15:0];
      end else if (state == RUN && ph) begin
        bus.dac_data     <= q_latch;
        bus.channel_sync <= 1'b0;
      end else begin
        bus.dac_data     <= 16'd0;
        bus.channel_sync <= 1'b0;
      end
    end
  end

  // Sticky underrun status with a saturating event count.
  // An underrun in the same cycle as a clear leaves count 1.
  always_ff @(posedge clk_dac0) begin
    if (reset) begin
      underrun_cnt  <= '0;
      underrun_flag <= 1'b0;
    end else if (clr_status) begin
      underrun_cnt  <= underrun_evt ? CNT_W'(1) : '0;
      underrun_flag <= underrun_evt;
    end else if (underrun_evt) begin
      underrun_flag <= 1'b1;
      if (underrun_cnt != CNT_MAX) begin
        underrun_cnt <= underrun_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_dac_tx_sequencer.sv
// Self-checking bench for dac_tx_sequencer with a FIFO model and a half-word scoreboard.
module tb_dac_tx_sequencer;

  logic        clk_dac0 = 1'b0;
  logic        reset;
  logic        enable;
  logic        test_mode;
  logic [31:0] test_word;
  logic        clr_status;
  logic        running;
  logic        underrun_flag;
  logic [3:0]  underrun_cnt;

  dac_tx_sequencer_if bus ();

  dac_tx_sequencer #(
    .UNDERRUN_LIMIT(4),
    .CNT_W         (4)
  ) dut (
    .clk_dac0     (clk_dac0),
    .reset        (reset),
    .enable       (enable),
    .test_mode    (test_mode),
    .test_word    (test_word),
    .clr_status   (clr_status),
    .bus          (bus.master),
    .running      (running),
    .underrun_flag(underrun_flag),
    .underrun_cnt (underrun_cnt)
  );

  always #5 clk_dac0 = ~clk_dac0;

  logic [31:0] fifo_q[$];   // FWFT FIFO contents
  logic [15:0] exp_q[$];    // expected half-words, in output order
  int          n_tests = 0;
  int          n_fail  = 0;
  int          pops    = 0;
  logic        prev_cs = 1'b0;
  logic        fs_exp  = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic upd_fifo();
    bus.fifo_empty = (fifo_q.size() == 0);
    bus.fifo_dout  = (fifo_q.size() != 0) ? fifo_q[0] : 32'd0;
  endtask

  task automatic load_word(input logic [31:0] w);
    fifo_q.push_back(w);
    exp_q.push_back(w[31:16]);
    exp_q.push_back(w[15:0]);
    upd_fifo();
  endtask

  task automatic expect_word(input logic [31:0] w);
    exp_q.push_back(w[31:16]);
    exp_q.push_back(w[15:0]);
  endtask

  // Called at a negedge. Runs one clock and returns at the next negedge with outputs settled.
  task automatic step();
    logic rd_pre;
    #1;
    rd_pre = bus.fifo_rd_en;
    @(posedge clk_dac0);
    #1;
    if (rd_pre) begin
      pops++;
      if (fifo_q.size() != 0) void'(fifo_q.pop_front());
      upd_fifo();
    end
    @(negedge clk_dac0);
  endtask

  // Compares the visible half-word against the scoreboard and checks frame_sync.
  task automatic observe();
    if (bus.channel_sync || prev_cs) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_half", {16'd0, bus.dac_data}, 32'hffff_ffff);
      end else begin
        check(bus.channel_sync ? "data_I" : "data_Q", {16'd0, bus.dac_data}, {16'd0, exp_q.pop_front()});
      end
    end else begin
      check("data_idle", {16'd0, bus.dac_data}, 32'd0);
    end
    if (bus.channel_sync) fs_exp = ~fs_exp;
    check("frame_sync", {31'd0, bus.frame_sync}, {31'd0, fs_exp});
    prev_cs = bus.channel_sync;
  endtask

  // Runs until n I halves are seen, then drops enable on the Q half and drains.
  task automatic run_words(input int n);
    int seen = 0;
    for (int c = 0; c < 80 && seen < n; c++) begin
      step();
      observe();
      if (bus.channel_sync) seen++;
    end
    check("words_seen", seen, n);
    enable = 1'b0;
    repeat (3) begin
      step();
      observe();
    end
    check("sb_drained", exp_q.size(), 0);
  endtask

  // One word from the FIFO followed by four underruns, then HALT. Enable is dropped at the end.
  task automatic halt_run(input logic [31:0] w);
    int pops0 = pops;
    load_word(w);
    repeat (4) expect_word(32'd0);
    enable = 1'b1;
    repeat (20) begin
      step();
      observe();
    end
    check("halt_running", {31'd0, running}, 32'd0);
    check("halt_pops", pops - pops0, 1);
    check("halt_sb_drained", exp_q.size(), 0);
    enable = 1'b0;
    step();
    observe();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   pops0;
    logic seen;
    reset      = 1'b1;
    enable     = 1'b0;
    test_mode  = 1'b0;
    test_word  = 32'd0;
    clr_status = 1'b0;
    upd_fifo();
    @(negedge clk_dac0);
    step();
    step();
    check("rst_dac_data", {16'd0, bus.dac_data}, 32'd0);
    check("rst_channel_sync", {31'd0, bus.channel_sync}, 32'd0);
    check("rst_frame_sync", {31'd0, bus.frame_sync}, 32'd0);
    check("rst_running", {31'd0, running}, 32'd0);
    check("rst_underrun_cnt", {28'd0, underrun_cnt}, 32'd0);
    check("rst_underrun_flag", {31'd0, underrun_flag}, 32'd0);
    check("rst_rd_en", {31'd0, bus.fifo_rd_en}, 32'd0);
    reset = 1'b0;
    step();

    // FIFO playback: two words, PRIME then RUN, exactly two pops.
    load_word(32'h1111_2222);
    load_word(32'h3333_4444);
    pops0  = pops;
    enable = 1'b1;
    step();
    observe();
    check("prime_running", {31'd0, running}, 32'd0);
    step();
    observe();
    check("run_running", {31'd0, running}, 32'd1);
    run_words(2);
    check("fifo_pops", pops - pops0, 2);
    check("fifo_no_underrun", {28'd0, underrun_cnt}, 32'd0);

    // Test-word mode with an empty FIFO: no pops and no underruns.
    test_mode = 1'b1;
    test_word = 32'hA5A5_5A5A;
    repeat (3) expect_word(32'hA5A5_5A5A);
    pops0  = pops;
    enable = 1'b1;
    run_words(3);
    check("test_pops", pops - pops0, 0);
    check("test_underrun_cnt", {28'd0, underrun_cnt}, 32'd0);

    // Underrun run to HALT, then back to IDLE and restart in test mode.
    test_mode = 1'b0;
    halt_run(32'hDEAD_BEEF);
    check("ur_cnt", {28'd0, underrun_cnt}, 32'd4);
    check("ur_flag", {31'd0, underrun_flag}, 32'd1);
    test_mode = 1'b1;
    test_word = 32'hC0DE_0F0F;
    expect_word(32'hC0DE_0F0F);
    enable = 1'b1;
    run_words(1);
    test_mode = 1'b0;

    // Clear in the same cycle as an underrun leaves count 1.
    load_word(32'h0BAD_F00D);
    expect_word(32'd0);
    enable = 1'b1;
    seen   = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      step();
      observe();
      seen = bus.channel_sync;
    end
    check("clr_reach_run", {31'd0, seen}, 32'd1);
    step();
    observe();
    clr_status = 1'b1;
    step();
    clr_status = 1'b0;
    observe();
    check("clr_evt_cnt", {28'd0, underrun_cnt}, 32'd1);
    check("clr_evt_flag", {31'd0, underrun_flag}, 32'd1);
    enable = 1'b0;
    repeat (3) begin
      step();
      observe();
    end
    check("clr_sb_drained", exp_q.size(), 0);
    clr_status = 1'b1;
    step();
    clr_status = 1'b0;
    observe();
    check("clr_cnt", {28'd0, underrun_cnt}, 32'd0);
    check("clr_flag", {31'd0, underrun_flag}, 32'd0);

    // Four halts give 16 underruns. A 4-bit counter must saturate at 15.
    for (int k = 0; k < 4; k++) halt_run(32'h1000_0001 + k);
    check("sat_cnt", {28'd0, underrun_cnt}, 32'd15);

    // Reset mid-RUN, asserted just before a pop slot.
    load_word(32'h5555_6666);
    load_word(32'h7777_8888);
    load_word(32'h9999_AAAA);
    enable = 1'b1;
    seen   = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      step();
      seen = bus.channel_sync;
    end
    check("rst_reach_run", {31'd0, seen}, 32'd1);
    step();
    reset = 1'b1;
    #1;
    check("rst_rd_en_0", {31'd0, bus.fifo_rd_en}, 32'd0);
    step();
    check("mid_rst_dac_data", {16'd0, bus.dac_data}, 32'd0);
    check("mid_rst_channel_sync", {31'd0, bus.channel_sync}, 32'd0);
    check("mid_rst_frame_sync", {31'd0, bus.frame_sync}, 32'd0);
    check("mid_rst_running", {31'd0, running}, 32'd0);
    check("mid_rst_underrun_cnt", {28'd0, underrun_cnt}, 32'd0);
    check("mid_rst_underrun_flag", {31'd0, underrun_flag}, 32'd0);
    #1;
    check("rst_rd_en_1", {31'd0, bus.fifo_rd_en}, 32'd0);
    step();
    check("rst_rd_en_2", {31'd0, bus.fifo_rd_en}, 32'd0);
    reset  = 1'b0;
    enable = 1'b0;
    fifo_q.delete();
    exp_q.delete();
    upd_fifo();
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dac_tx_sequencer.md
DAC_TX_SEQUENCER -- requirements
Module: dac_tx_sequencer

Interface
REQ-001 SHALL have parameter UNDERRUN_LIMIT, default 16: consecutive underrun word slots that force HALT; legal range 1..255.
REQ-002 SHALL have parameter CNT_W, default 16: width of underrun_cnt.
REQ-003 clk_dac0  in  1  DAC word clock; all logic on its rising edge.
REQ-004 reset  in  1  synchronous, active-high.
REQ-005 enable  in  1  level run request.
REQ-006 test_mode  in  1  1 = source is test_word, 0 = source is FIFO.
REQ-007 test_word  in  32  constant IQ word: I in [31:16], Q in [15:0].
REQ-008 clr_status  in  1  single-cycle clear of underrun_cnt and underrun_flag.
REQ-009 fifo_empty  in  1  sample FIFO empty; first-word-fall-through.
REQ-010 fifo_dout  in  32  FIFO head word; valid when fifo_empty=0.
REQ-011 fifo_rd_en  out  1  combinational pop strobe.
REQ-012 dac_data  out  16  registered half-word for the DDR serializer.
REQ-013 channel_sync  out  1  registered; 1 when dac_data holds I half.
REQ-014 frame_sync  out  1  registered; toggles with each new I half.
REQ-015 running  out  1  registered; 1 in RUN only.
REQ-016 underrun_flag  out  1  sticky underrun indicator.
REQ-017 underrun_cnt  out  CNT_W  saturating total underrun word count.

Function
REQ-018 States SHALL be IDLE, PRIME, RUN and HALT; internal phase bit ph SHALL be 0 on RUN entry and toggle every RUN cycle.
REQ-019 IDLE: if enable=1, go to PRIME next cycle; otherwise stay in IDLE.
REQ-020 PRIME: if enable=0, go to IDLE; else go to RUN when (test_mode=1 or fifo_empty=0); else stay in PRIME.
REQ-021 RUN, ph=0 (word boundary), enable=0: go to IDLE and do not pop.
REQ-022 RUN, ph=0, enable=1: select the word source.
- test_mode=1: source = test_word.
- test_mode=0 and fifo_empty=0: source = fifo_dout; fifo_rd_en=1 in that cycle.
- test_mode=0 and fifo_empty=1: source = 0; this is an underrun event.
REQ-023 On RUN, ph=0, enable=1, the block SHALL register dac_data<=source[31:16], channel_sync<=1, frame_sync<=~frame_sync, and latch source[15:0].
REQ-024 RUN, ph=1: dac_data<=latched [15:0] and channel_sync<=0; enable and test_mode changes SHALL NOT take effect until the next ph=0 cycle.
REQ-025 fifo_rd_en SHALL be 1 only under REQ-022 with a FIFO pop, so at most one pop occurs per 2 cycles.
REQ-026 Underrun handling:
- The consecutive-underrun counter increments on each underrun event and clears on any non-underrun word.
- When it reaches UNDERRUN_LIMIT, the state goes to HALT in the same transition.
REQ-027 HALT: stay until enable=0, then go to IDLE.
REQ-028 In IDLE, PRIME and HALT, the block SHALL drive dac_data=0, channel_sync=0, fifo_rd_en=0 and running=0, and hold frame_sync.
REQ-029 underrun_cnt SHALL increment by 1 per underrun event and saturate at all-ones.
REQ-030 underrun_flag SHALL set on any underrun event.
REQ-031 clr_status=1 SHALL zero underrun_cnt and underrun_flag; if an underrun event occurs in the same cycle, the result SHALL be underrun_cnt=1 and underrun_flag=1.
REQ-032 Latency from the pop cycle: I half appears on dac_data 1 cycle after the pop, and Q half 2 cycles after the pop.

Reset
REQ-033 While reset=1, fifo_rd_en SHALL be 0.
REQ-034 On reset=1 the block SHALL take effect on the next edge, regardless of state or phase, and drive: state=IDLE, ph=0, dac_data=0, channel_sync=0, frame_sync=0, running=0, underrun_cnt=0, underrun_flag=0, consecutive-underrun counter=0.

Verification
REQ-035 Preload the FIFO with 0x11112222, 0x33334444; set enable=1.
- Expect PRIME then RUN.
- Expect dac_data sequence 0x1111, 0x2222, 0x3333, 0x4444.
- Expect channel_sync 1,0,1,0; frame_sync toggling on each I half; exactly 2 pops.
REQ-036 With test_mode=1, test_word=0xA5A55A5A and an empty FIFO, set enable=1.
- Expect dac_data alternating 0xA5A5/0x5A5A with no pops and underrun_cnt=0.
REQ-037 In RUN with the FIFO emptied and UNDERRUN_LIMIT=4:
- Expect 4 zero words, underrun_cnt=4, underrun_flag=1 and HALT (running=0).
- Deassert enable: expect IDLE.
REQ-038 Deassert enable during ph=1: expect the Q half still output, then IDLE, with no further pop.
REQ-039 Assert clr_status in the same cycle as an underrun event: expect underrun_cnt=1.
REQ-040 Assert reset mid-RUN: expect all outputs 0 the next cycle and fifo_rd_en=0 throughout reset.
